reg_list_sequencer: RTL and testbench
=====================================

// Module: reg_list_sequencer
// PURPOSE
//  Block-transfer (LDM/STM) controller. Walks a 16-bit register list in
//  ascending register order and emits one register number plus one word
//  address per memory handshake.
//  Its rf_addr output feeds the 5-bit 2:1 register-address mux as D1, and
//  rf_sel drives that mux's select. With rf_sel=0 the decoder field passes
//  through; with rf_sel=1 the sequencer owns the register-file port.
// PARAMETERS
//  LIST_W  16  register-list width; one bit per architectural register
//  RN_W    5   register-number width; matches the 5-bit mux datapath
//  ADDR_W  32  memory address width
// PORTS
//  clk         in   1       system clock; all state updates on rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  start       in   1       one-cycle request; sampled only in IDLE
//  reg_list    in   LIST_W  bit i set = transfer register i
//  base_addr   in   ADDR_W  base register value Rn
//  up          in   1       1 = increment-after, 0 = decrement-before
//  wb_req      in   1       write back the final base (the W bit)
//  xfer_ready  in   1       memory accepts the current transfer
//  xfer_valid  out  1       current rf_addr/mem_addr pair is valid
//  rf_addr     out  RN_W    register number for the current transfer
//  mem_addr    out  ADDR_W  word address for the current transfer
//  rf_sel      out  1       register-address mux select; 1 while in XFER
//  busy        out  1       high in XFER and DONE
//  done        out  1       one-cycle completion pulse
//  wb_valid    out  1       one-cycle base-writeback strobe
//  wb_addr     out  ADDR_W  new base value; valid while wb_valid=1
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, pending list cleared.
//  States: IDLE -> XFER -> DONE -> IDLE.
//  - IDLE:
//    - start=1 latches reg_list, base_addr, up and wb_req.
//    - Next state is XFER if the list is non-zero, else DONE.
//    - start is ignored in all other states; there is no queueing.
//  - XFER:
//    - xfer_valid=1 and rf_sel=1.
//    - rf_addr = index of the lowest set pending bit, zero-extended to RN_W.
//    - On xfer_valid & xfer_ready: clear that pending bit and add 4 to
//      mem_addr, modulo 2^ADDR_W.
//    - If the bit just cleared was the last one, go to DONE in that cycle.
//    - xfer_ready=0 holds rf_addr and mem_addr stable.
//  - DONE: done=1 for one cycle, then return to IDLE.
//  - Start address, with n = popcount(list):
//    - up=1: base_addr
//    - up=0: base_addr - 4*n
//  - Final base, modulo 2^ADDR_W:
//    - up=1: base_addr + 4*n
//    - up=0: base_addr - 4*n
//  - Latency with xfer_ready held high, start sampled at cycle 0:
//    - transfers occur in cycles 1..n
//    - done occurs in cycle n+1
//  - Empty list: done in cycle 1, no xfer_valid, and the base is unchanged.
//  - Reset mid-operation: abort immediately. No done pulse. rf_sel drops to 0.
// CONFIGURATION
//  Macro REG_SEQ_WRITEBACK_EN.
//  - Defined: in DONE, wb_valid = latched wb_req and wb_addr = final base.
//    An empty list with wb_req set gives wb_addr = base_addr.
//  - Undefined: wb_valid and wb_addr are tied to 0, and wb_req is ignored.
// STRUCTURE
//  Package reg_seq_pkg holds:
//  - the state enum: IDLE, XFER, DONE
//  - the constant WORD_BYTES = 4
//  - the function popcount16
//  Sub-module lowest_set_enc: combinational priority encoder, LIST_W bits
//  in, RN_W-bit index plus an any-set flag out.
// TESTING
//  1. Ascending: list=0x0005, base=0x100, up=1, wb_req=1, ready=1.
//     -> (r0, 0x100) in cycle 1, (r2, 0x104) in cycle 2.
//     -> done and wb_addr=0x108 in cycle 3.
//  2. Decrement: list=0x8001, base=0x200, up=0.
//     -> (r0, 0x1F8) then (r15, 0x1FC); wb_addr=0x1F8.
//  3. Stall: ready=0 for 2 cycles on the first beat of list=0x0003.
//     -> rf_addr=0 and mem_addr stay stable, xfer_valid stays 1.
//     -> After release, (r1, base+4) follows.
//  4. Empty list at base=0x40.
//     -> done in cycle 1 with zero xfer_valid cycles.
//     -> wb_addr=0x40 if the macro is defined.
//  5. Assert start again during XFER of list=0x00F0.
//     -> ignored; exactly 4 transfers, r4 through r7.
//  6. Drive rst_n low during beat 2 of list=0xFFFF.
//     -> All outputs are 0 immediately and no done pulse occurs.
//     -> A new start after reset runs normally.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared types and helpers for the LDM/STM register-list sequencer.
package reg_seq_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} seq_state_e;

  localparam int WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_enc.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_enc #(
  parameter int LIST_W = 16,
  parameter int RN_W   = 5
) (
  input  logic [LIST_W-1:0] list,
  output logic [RN_W-1:0]   idx,
  output logic              any
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--)
      if (list[i]) idx = RN_W'(i);
  end

  assign any = |list;

endmodule

// File: rtl/reg_list_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list in ascending order,
// one register/address pair per memory handshake. Build with
// REG_SEQ_WRITEBACK_EN to enable the final-base writeback strobe.
module reg_list_sequencer
  import reg_seq_pkg::*;
#(
  parameter int LIST_W = 16,
  parameter int RN_W   = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              up,
  input  logic              wb_req,
  input  logic              xfer_ready,
  output logic              xfer_valid,
  output logic [RN_W-1:0]   rf_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rf_sel,
  output logic              busy,
  output logic              done,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);

  seq_state_e        state;
  logic [LIST_W-1:0] pending;
  logic [LIST_W-1:0] pending_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ofs;
  logic [RN_W-1:0]   enc_idx;
  logic              enc_any;
  logic              fire;

  lowest_set_enc #(.LIST_W(LIST_W), .RN_W(RN_W)) u_enc (
    .list (pending),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Clearing the lowest set bit is exactly the beat the encoder just named.
  assign pending_nxt = pending & (pending - LIST_W'(1));
  assign ofs         = ADDR_W'(popcount16(16'(reg_list))) * ADDR_W'(WORD_BYTES);
  assign fire        = xfer_valid & xfer_ready;

`ifdef REG_SEQ_WRITEBACK_EN
  logic              wb_q;
  logic [ADDR_W-1:0] wb_addr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      addr_q  <= '0;
`ifdef REG_SEQ_WRITEBACK_EN
      wb_q      <= 1'b0;
      wb_addr_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          pending <= reg_list;
          addr_q  <= up ? base_addr : base_addr - ofs;
`ifdef REG_SEQ_WRITEBACK_EN
          wb_q      <= wb_req;
          wb_addr_q <= up ? base_addr + ofs : base_addr - ofs;
`endif
          state   <= (|reg_list) ? XFER : DONE;
        end
        XFER: if (fire) begin
          pending <= pending_nxt;
          addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
          if (pending_nxt == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_sel     = (state == XFER);
  assign xfer_valid = rf_sel & enc_any;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rf_addr    = rf_sel ? enc_idx : '0;
  assign mem_addr   = rf_sel ? addr_q  : '0;

`ifdef REG_SEQ_WRITEBACK_EN
  assign wb_valid = done & wb_q;
  assign wb_addr  = wb_valid ? wb_addr_q : '0;
`else
  logic unused_wb;
  assign unused_wb = wb_req;
  assign wb_valid  = 1'b0;
  assign wb_addr   = '0;
`endif

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Self-checking bench for reg_list_sequencer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_reg_list_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic        up = 1'b1;
  logic        wb_req = 1'b0;
  logic        xfer_ready = 1'b1;
  logic        xfer_valid;
  logic [4:0]  rf_addr;
  logic [31:0] mem_addr;
  logic        rf_sel;
  logic        busy;
  logic        done;
  logic        wb_valid;
  logic [31:0] wb_addr;

  reg_list_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reg_list(reg_list),
    .base_addr(base_addr), .up(up), .wb_req(wb_req), .xfer_ready(xfer_ready),
    .xfer_valid(xfer_valid), .rf_addr(rf_addr), .mem_addr(mem_addr),
    .rf_sel(rf_sel), .busy(busy), .done(done), .wb_valid(wb_valid),
    .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

`ifdef REG_SEQ_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  // Reference model: phase 0 idle, 1 transferring, 2 done.
  int          m_ph = 0;
  int          m_rn[$];
  logic [31:0] m_ad[$];
  logic [31:0] m_fin = '0;
  logic        m_wbv = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_rn.delete(); m_ad.delete(); m_wbv = 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          int n;
          int k;
          logic [31:0] st;
          n  = $countones(reg_list);
          st = up ? base_addr : base_addr - 32'(4 * n);
          m_rn.delete(); m_ad.delete();
          k = 0;
          for (int i = 0; i < 16; i++)
            if (reg_list[i]) begin
              m_rn.push_back(i);
              m_ad.push_back(st + 32'(4 * k));
              k++;
            end
          m_fin = up ? base_addr + 32'(4 * n) : base_addr - 32'(4 * n);
          m_wbv = wb_req;
          m_ph  = (n == 0) ? 2 : 1;
        end
        1: if (xfer_ready) begin
          void'(m_rn.pop_front());
          void'(m_ad.pop_front());
          if (m_rn.size() == 0) m_ph = 2;
        end
        default: m_ph = 0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observed activity log, relative to the cycle in which start was sampled.
  int          lg_rel[$];
  int          lg_rn[$];
  logic [31:0] lg_ad[$];
  bit          done_seen = 1'b0;
  int          done_rel = -1;
  logic        done_wbv = 1'b0;
  logic [31:0] done_wba = '0;

  initial forever begin
    logic ex;
    logic ewv;
    @(negedge clk);
    ex  = (m_ph == 1);
    ewv = WB_EN && (m_ph == 2) && m_wbv;
    chk("xfer_valid", xfer_valid, ex);
    chk("rf_sel", rf_sel, ex);
    chk("busy", busy, m_ph != 0);
    chk("done", done, m_ph == 2);
    chk("wb_valid", wb_valid, ewv);
    if (ex) begin
      chk("rf_addr", rf_addr, 64'(m_rn[0]));
      chk("mem_addr", mem_addr, m_ad[0]);
    end
    if (ewv) chk("wb_addr", wb_addr, m_fin);
    if (xfer_valid && xfer_ready) begin
      lg_rel.push_back(cyc - start_cyc);
      lg_rn.push_back(int'(rf_addr));
      lg_ad.push_back(mem_addr);
    end
    if (done) begin
      done_seen = 1'b1;
      done_rel  = cyc - start_cyc;
      done_wbv  = wb_valid;
      done_wba  = wb_addr;
    end
  end

  task automatic start_op(input logic [15:0] l, input logic [31:0] b,
                          input logic u, input logic w);
    @(posedge clk); #1;
    start = 1'b1; reg_list = l; base_addr = b; up = u; wb_req = w;
    start_cyc = cyc;
    lg_rel.delete(); lg_rn.delete(); lg_ad.delete();
    done_seen = 1'b0; done_rel = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done_seen && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, done_seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_beat(input string nm, input int k, input int rel,
                          input int rn, input logic [31:0] ad);
    if (lg_rel.size() > k) begin
      chk({nm, "_rel"}, 64'(lg_rel[k]), 64'(rel));
      chk({nm, "_rn"}, 64'(lg_rn[k]), 64'(rn));
      chk({nm, "_addr"}, lg_ad[k], ad);
    end else chk({nm, "_present"}, 0, 1);
  endtask

  task automatic chk_wb(input string nm, input logic [31:0] ad);
    chk({nm, "_wbv"}, done_wbv, WB_EN);
    chk({nm, "_wba"}, done_wba, WB_EN ? ad : 32'h0);
  endtask

  initial begin
    #2;
    chk("rst_xfer_valid", xfer_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_sel", rf_sel, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: ascending with writeback
    start_op(16'h0005, 32'h100, 1'b1, 1'b1);
    wait_done("t1");
    chk("t1_n", lg_rel.size(), 2);
    chk_beat("t1_b0", 0, 1, 0, 32'h100);
    chk_beat("t1_b1", 1, 2, 2, 32'h104);
    chk("t1_done_cyc", 64'(done_rel), 3);
    chk_wb("t1", 32'h108);

    // 2: decrement-before
    start_op(16'h8001, 32'h200, 1'b0, 1'b1);
    wait_done("t2");
    chk("t2_n", lg_rel.size(), 2);
    chk_beat("t2_b0", 0, 1, 0, 32'h1F8);
    chk_beat("t2_b1", 1, 2, 15, 32'h1FC);
    chk_wb("t2", 32'h1F8);

    // 3: stall on the first beat for two cycles
    xfer_ready = 1'b0;
    start_op(16'h0003, 32'h300, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    xfer_ready = 1'b1;
    wait_done("t3");
    chk("t3_n", lg_rel.size(), 2);
    chk_beat("t3_b0", 0, 3, 0, 32'h300);
    chk_beat("t3_b1", 1, 4, 1, 32'h304);
    chk("t3_done_cyc", 64'(done_rel), 5);
    chk("t3_wbv", done_wbv, 0);

    // 4: empty list
    start_op(16'h0000, 32'h40, 1'b1, 1'b1);
    wait_done("t4");
    chk("t4_n", lg_rel.size(), 0);
    chk("t4_done_cyc", 64'(done_rel), 1);
    chk_wb("t4", 32'h40);

    // 5: start re-asserted mid-transfer is ignored
    start_op(16'h00F0, 32'h80, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; reg_list = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5");
    chk("t5_n", lg_rel.size(), 4);
    chk_beat("t5_b0", 0, 1, 4, 32'h80);
    chk_beat("t5_b3", 3, 4, 7, 32'h8C);
    chk("t5_done_cyc", 64'(done_rel), 5);

    // 6: reset during beat 2
    start_op(16'hFFFF, 32'h1000, 1'b1, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_xfer_valid", xfer_valid, 0);
    chk("t6_rf_sel", rf_sel, 0);
    chk("t6_rf_addr", rf_addr, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_wb", {wb_valid, wb_addr}, 0);
    chk("t6_beats", lg_rel.size(), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("t6_no_done", done_seen, 0);

    start_op(16'h0005, 32'h100, 1'b1, 1'b1);
    wait_done("t6r");
    chk_beat("t6r_b0", 0, 1, 0, 32'h100);
    chk_beat("t6r_b1", 1, 2, 2, 32'h104);
    chk_wb("t6r", 32'h108);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
